// File: rtl/ibex_obi_ahb_bridge_if.sv
// Bus bundle for the Ibex OBI-to-AHB-Lite bridge: both OBI ports plus the AHB-Lite master port.
// The master modport is the bridge's view; slave is the core/interconnect view.
interface ibex_obi_ahb_bridge_if #(
    parameter int ADDR_W = 32
);
    logic              instr_req_i;
    logic [ADDR_W-1:0] instr_addr_i;
    logic              instr_gnt_o;
    logic              instr_rvalid_o;
    logic [31:0]       instr_rdata_o;
    logic              instr_err_o;

    logic              data_req_i;
    logic              data_we_i;
    logic [3:0]        data_be_i;
    logic [ADDR_W-1:0] data_addr_i;
    logic [31:0]       data_wdata_i;
    logic              data_gnt_o;
    logic              data_rvalid_o;
    logic [31:0]       data_rdata_o;
    logic              data_err_o;

    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic [2:0]        HSIZE;
    logic              HWRITE;
    logic [3:0]        HPROT;
    logic [31:0]       HWDATA;
    logic [31:0]       HRDATA;
    logic              HREADY;
    logic              HRESP;

    modport master (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output HADDR, HTRANS, HSIZE, HWRITE, HPROT, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  HADDR, HTRANS, HSIZE, HWRITE, HPROT, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ibex_obi_ahb_bridge.sv
// Ibex instruction/data OBI ports arbitrated onto one AHB-Lite master with separate address and
// data phases. OBI handshake: gnt pulses in the IDLE cycle that accepts req; rvalid pulses once.
module ibex_obi_ahb_bridge #(
    parameter int ADDR_W     = 32,
    parameter int ARB_MODE   = 0,
    parameter int HPROT_PRIV = 1
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    ibex_obi_ahb_bridge_if.master  bus,
    output logic [1:0]             state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, ERR = 2'd3} state_e;

    localparam logic PRIV_BIT = (HPROT_PRIV != 0);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;        // 1 = data port owns the transfer
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [2:0]        size_q, size_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rr_data_q, rr_data_d;    // data wins the next contested grant
    logic              instr_rvalid_q, instr_rvalid_d;
    logic              data_rvalid_q, data_rvalid_d;
    logic              err_q, err_d;
    logic [31:0]       instr_rdata_q, instr_rdata_d;
    logic [31:0]       data_rdata_q, data_rdata_d;

    logic              be_legal;
    logic [2:0]        be_size;
    logic [1:0]        be_off;
    logic              pick_data;

    always_comb begin
        be_legal = 1'b1;
        be_size  = 3'b000;
        be_off   = 2'b00;
        case (bus.data_be_i)
            4'b0001: be_off = 2'd0;
            4'b0010: be_off = 2'd1;
            4'b0100: be_off = 2'd2;
            4'b1000: be_off = 2'd3;
            4'b0011: be_size = 3'b001;
            4'b1100: begin be_size = 3'b001; be_off = 2'd2; end
            4'b1111: be_size = 3'b010;
            default: be_legal = 1'b0;
        endcase
    end

    assign pick_data = bus.data_req_i &&
                       (!bus.instr_req_i || (ARB_MODE == 0) || rr_data_q);

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        addr_d         = addr_q;
        we_d           = we_q;
        size_d         = size_q;
        wdata_d        = wdata_q;
        rr_data_d      = rr_data_q;
        instr_rvalid_d = 1'b0;
        data_rvalid_d  = 1'b0;
        err_d          = 1'b0;
        instr_rdata_d  = instr_rdata_q;
        data_rdata_d   = data_rdata_q;
        bus.instr_gnt_o = 1'b0;
        bus.data_gnt_o  = 1'b0;
        bus.HADDR       = '0;
        bus.HTRANS      = 2'b00;
        bus.HSIZE       = 3'b000;
        bus.HWRITE      = 1'b0;
        bus.HPROT       = 4'b0000;
        bus.HWDATA      = 32'h0;
        case (state_q)
            IDLE: begin
                if (bus.instr_req_i && bus.data_req_i) rr_data_d = !pick_data;
                if (pick_data) begin
                    bus.data_gnt_o = 1'b1;
                    owner_d = 1'b1;
                    addr_d  = {bus.data_addr_i[ADDR_W-1:2], be_off};
                    we_d    = bus.data_we_i;
                    size_d  = be_size;
                    wdata_d = bus.data_wdata_i;
                    if (be_legal) begin
                        state_d = ADDR;
                    end else begin
                        // Illegal byte-enables are answered immediately without touching AHB.
                        state_d       = ERR;
                        data_rvalid_d = 1'b1;
                        err_d         = 1'b1;
                        data_rdata_d  = 32'h0;
                    end
                end else if (bus.instr_req_i) begin
                    bus.instr_gnt_o = 1'b1;
                    owner_d = 1'b0;
                    addr_d  = {bus.instr_addr_i[ADDR_W-1:2], 2'b00};
                    we_d    = 1'b0;
                    size_d  = 3'b010;
                    wdata_d = 32'h0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                bus.HTRANS = 2'b10;
                bus.HADDR  = addr_q;
                bus.HSIZE  = size_q;
                bus.HWRITE = we_q;
                bus.HPROT  = {2'b00, PRIV_BIT, owner_q};
                if (bus.HREADY) state_d = DATA;
            end
            DATA: begin
                bus.HWDATA = wdata_q;
                if (bus.HREADY) begin
                    state_d = IDLE;
                    err_d   = bus.HRESP;
                    if (owner_q) begin
                        data_rvalid_d = 1'b1;
                        data_rdata_d  = we_q ? 32'h0 : bus.HRDATA;
                    end else begin
                        instr_rvalid_d = 1'b1;
                        instr_rdata_d  = bus.HRDATA;
                    end
                end
            end
            ERR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q        <= IDLE;
            owner_q        <= 1'b0;
            addr_q         <= '0;
            we_q           <= 1'b0;
            size_q         <= 3'b000;
            wdata_q        <= 32'h0;
            rr_data_q      <= 1'b1;
            instr_rvalid_q <= 1'b0;
            data_rvalid_q  <= 1'b0;
            err_q          <= 1'b0;
            instr_rdata_q  <= 32'h0;
            data_rdata_q   <= 32'h0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            addr_q         <= addr_d;
            we_q           <= we_d;
            size_q         <= size_d;
            wdata_q        <= wdata_d;
            rr_data_q      <= rr_data_d;
            instr_rvalid_q <= instr_rvalid_d;
            data_rvalid_q  <= data_rvalid_d;
            err_q          <= err_d;
            instr_rdata_q  <= instr_rdata_d;
            data_rdata_q   <= data_rdata_d;
        end
    end

    assign bus.instr_rvalid_o = instr_rvalid_q;
    assign bus.instr_err_o    = instr_rvalid_q & err_q;
    assign bus.instr_rdata_o  = instr_rdata_q;
    assign bus.data_rvalid_o  = data_rvalid_q;
    assign bus.data_err_o     = data_rvalid_q & err_q;
    assign bus.data_rdata_o   = data_rdata_q;
    assign state_o            = state_q;
endmodule

// File: tb/tb_ibex_obi_ahb_bridge.sv
// Directed bench for ibex_obi_ahb_bridge: fixed-priority and round-robin instances share stimulus;
// responses of the fixed-priority instance are scoreboarded as {instr_rv, data_rv, err, rdata}.
module tb_ibex_obi_ahb_bridge;
    localparam int W = 35;

    logic HCLK = 1'b0;
    logic HRESETn;
    logic [1:0] st0, st1;
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    always #5 HCLK = ~HCLK;

    ibex_obi_ahb_bridge_if #(.ADDR_W(32)) if0 ();
    ibex_obi_ahb_bridge_if #(.ADDR_W(32)) if1 ();

    ibex_obi_ahb_bridge #(.ADDR_W(32), .ARB_MODE(0), .HPROT_PRIV(1)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(if0), .state_o(st0));
    ibex_obi_ahb_bridge #(.ADDR_W(32), .ARB_MODE(1), .HPROT_PRIV(1)) dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(if1), .state_o(st1));

    assign if1.instr_req_i  = if0.instr_req_i;
    assign if1.instr_addr_i = if0.instr_addr_i;
    assign if1.data_req_i   = if0.data_req_i;
    assign if1.data_we_i    = if0.data_we_i;
    assign if1.data_be_i    = if0.data_be_i;
    assign if1.data_addr_i  = if0.data_addr_i;
    assign if1.data_wdata_i = if0.data_wdata_i;
    assign if1.HRDATA       = if0.HRDATA;
    assign if1.HREADY       = if0.HREADY;
    assign if1.HRESP        = if0.HRESP;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic neg();
        @(negedge HCLK);
    endtask

    task automatic drop_reqs();
        if0.instr_req_i  = 1'b0;
        if0.instr_addr_i = 32'h0;
        if0.data_req_i   = 1'b0;
        if0.data_we_i    = 1'b0;
        if0.data_be_i    = 4'h0;
        if0.data_addr_i  = 32'h0;
        if0.data_wdata_i = 32'h0;
    endtask

    // Response scoreboard
    always @(negedge HCLK) begin : mon
        logic [W-1:0] e;
        logic [W-1:0] o;
        if (HRESETn === 1'b1 && (if0.instr_rvalid_o || if0.data_rvalid_o)) begin
            o = {if0.instr_rvalid_o, if0.data_rvalid_o, if0.instr_err_o | if0.data_err_o,
                 if0.instr_rvalid_o ? if0.instr_rdata_o : if0.data_rdata_o};
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {62'd0, if0.instr_rvalid_o, if0.data_rvalid_o}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp", {29'd0, o}, {29'd0, e});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        drop_reqs();
        if0.HRDATA = 32'h0;
        if0.HREADY = 1'b1;
        if0.HRESP  = 1'b0;
        HRESETn    = 1'b0;
        repeat (3) cyc();
        neg();
        chk("rst_htrans", if0.HTRANS, 2'b00);
        chk("rst_haddr", if0.HADDR, 32'h0);
        chk("rst_state", st0, 2'd0);
        chk("rst_gnt", {if0.instr_gnt_o, if0.data_gnt_o}, 2'b00);
        chk("rst_rvalid", {if0.instr_rvalid_o, if0.data_rvalid_o}, 2'b00);
        cyc();
        HRESETn = 1'b1;
        cyc();

        // Instruction fetch, zero wait
        if0.instr_req_i = 1'b1; if0.instr_addr_i = 32'h100; if0.HRDATA = 32'h13;
        neg();
        chk("f_ignt", if0.instr_gnt_o, 1'b1);
        chk("f_dgnt", if0.data_gnt_o, 1'b0);
        exp_q.push_back({1'b1, 1'b0, 1'b0, 32'h13});
        cyc(); drop_reqs();
        neg();
        chk("f_htrans", if0.HTRANS, 2'b10);
        chk("f_haddr", if0.HADDR, 32'h100);
        chk("f_hsize", if0.HSIZE, 3'b010);
        chk("f_hprot", if0.HPROT, 4'b0010);
        chk("f_hwrite", if0.HWRITE, 1'b0);
        cyc(); neg();
        chk("f_dphase_htrans", if0.HTRANS, 2'b00);
        chk("f_dphase_haddr", if0.HADDR, 32'h0);
        chk("f_dphase_state", st0, 2'd2);
        cyc(); neg();
        chk("f_rvalid_t3", if0.instr_rvalid_o, 1'b1);
        chk("f_idle_t3", st0, 2'd0);
        cyc();

        // Byte store with two data-phase wait states; an instruction request waits behind it
        if0.data_req_i = 1'b1; if0.data_we_i = 1'b1; if0.data_be_i = 4'b0100;
        if0.data_addr_i = 32'h2000; if0.data_wdata_i = 32'h00AB0000; if0.HRDATA = 32'h99;
        neg();
        chk("st_dgnt", if0.data_gnt_o, 1'b1);
        exp_q.push_back({1'b0, 1'b1, 1'b0, 32'h0});
        cyc(); drop_reqs();
        neg();
        chk("st_htrans", if0.HTRANS, 2'b10);
        chk("st_haddr", if0.HADDR, 32'h2002);
        chk("st_hsize", if0.HSIZE, 3'b000);
        chk("st_hwrite", if0.HWRITE, 1'b1);
        chk("st_hprot", if0.HPROT, 4'b0011);
        cyc();
        if0.HREADY = 1'b0; if0.instr_req_i = 1'b1; if0.instr_addr_i = 32'h203;
        neg();
        chk("st_hwdata", if0.HWDATA, 32'h00AB0000);
        chk("st_dphase_htrans", if0.HTRANS, 2'b00);
        chk("busy_ignt_a", if0.instr_gnt_o, 1'b0);
        cyc(); neg();
        chk("busy_ignt_b", if0.instr_gnt_o, 1'b0);
        chk("st_wait_rvalid", if0.data_rvalid_o, 1'b0);
        cyc(); if0.HREADY = 1'b1;
        neg();
        chk("st_hwdata_hold", if0.HWDATA, 32'h00AB0000);
        chk("st_no_rvalid_t4", if0.data_rvalid_o, 1'b0);
        chk("busy_ignt_c", if0.instr_gnt_o, 1'b0);
        cyc(); if0.HRDATA = 32'h11223344;
        neg();
        chk("st_rvalid_t5", if0.data_rvalid_o, 1'b1);
        chk("b2b_ignt", if0.instr_gnt_o, 1'b1);
        exp_q.push_back({1'b1, 1'b0, 1'b0, 32'h11223344});
        cyc(); drop_reqs();
        neg();
        chk("b2b_haddr_align", if0.HADDR, 32'h200);
        chk("b2b_hprot", if0.HPROT, 4'b0010);
        cyc(); neg(); cyc(); neg();
        chk("b2b_rvalid", if0.instr_rvalid_o, 1'b1);
        cyc();

        // Contested requests, four grants
        if0.instr_req_i = 1'b1; if0.instr_addr_i = 32'h40;
        if0.data_req_i = 1'b1; if0.data_we_i = 1'b0; if0.data_be_i = 4'b1111;
        if0.data_addr_i = 32'h80; if0.HRDATA = 32'hCAFE0001;
        for (int i = 0; i < 4; i++) begin
            neg();
            chk("arb_fixed_d", if0.data_gnt_o, 1'b1);
            chk("arb_fixed_i", if0.instr_gnt_o, 1'b0);
            chk("arb_rr_d", if1.data_gnt_o, (i % 2) == 0);
            chk("arb_rr_i", if1.instr_gnt_o, (i % 2) == 1);
            exp_q.push_back({1'b0, 1'b1, 1'b0, 32'hCAFE0001});
            cyc();
            if (i == 3) drop_reqs();
            cyc(); cyc();
        end
        neg(); cyc();

        // Data read with two-cycle HRESP error
        if0.data_req_i = 1'b1; if0.data_be_i = 4'b1111; if0.data_addr_i = 32'h3000;
        if0.HRDATA = 32'hDEADBEEF;
        neg();
        chk("er_dgnt", if0.data_gnt_o, 1'b1);
        exp_q.push_back({1'b0, 1'b1, 1'b1, 32'hDEADBEEF});
        cyc(); drop_reqs();
        neg();
        chk("er_haddr", if0.HADDR, 32'h3000);
        chk("er_hsize", if0.HSIZE, 3'b010);
        cyc(); if0.HREADY = 1'b0; if0.HRESP = 1'b1;
        neg();
        cyc(); if0.HREADY = 1'b1;
        neg();
        chk("er_no_rvalid", if0.data_rvalid_o, 1'b0);
        cyc(); if0.HRESP = 1'b0;
        neg();
        chk("er_rvalid", if0.data_rvalid_o, 1'b1);
        chk("er_err", if0.data_err_o, 1'b1);
        cyc();

        // Illegal byte-enable
        if0.data_req_i = 1'b1; if0.data_we_i = 1'b1; if0.data_be_i = 4'b0101;
        if0.data_addr_i = 32'h4000; if0.data_wdata_i = 32'h1;
        neg();
        chk("ill_dgnt", if0.data_gnt_o, 1'b1);
        chk("ill_htrans_t0", if0.HTRANS, 2'b00);
        exp_q.push_back({1'b0, 1'b1, 1'b1, 32'h0});
        cyc(); drop_reqs();
        neg();
        chk("ill_htrans_t1", if0.HTRANS, 2'b00);
        chk("ill_rvalid", if0.data_rvalid_o, 1'b1);
        chk("ill_err", if0.data_err_o, 1'b1);
        chk("ill_state", st0, 2'd3);
        cyc(); neg();
        chk("ill_htrans_t2", if0.HTRANS, 2'b00);
        chk("ill_idle", st0, 2'd0);
        chk("ill_rvalid_once", if0.data_rvalid_o, 1'b0);
        cyc();

        // Reset during a stalled data phase
        if0.data_req_i = 1'b1; if0.data_be_i = 4'b1111; if0.data_addr_i = 32'h5000;
        neg();
        chk("rm_dgnt", if0.data_gnt_o, 1'b1);
        cyc(); drop_reqs();
        neg(); cyc(); if0.HREADY = 1'b0;
        neg();
        chk("rm_in_data", st0, 2'd2);
        HRESETn = 1'b0;
        #1;
        chk("rm_state", st0, 2'd0);
        chk("rm_htrans", if0.HTRANS, 2'b00);
        cyc(); if0.HREADY = 1'b1;
        neg();
        chk("rm_no_rvalid", {if0.instr_rvalid_o, if0.data_rvalid_o}, 2'b00);
        cyc(); HRESETn = 1'b1;
        cyc();

        // Halfword read after reset
        if0.data_req_i = 1'b1; if0.data_be_i = 4'b1100; if0.data_addr_i = 32'h7000;
        if0.HRDATA = 32'hABCD0000;
        neg();
        chk("hw_dgnt", if0.data_gnt_o, 1'b1);
        exp_q.push_back({1'b0, 1'b1, 1'b0, 32'hABCD0000});
        cyc(); drop_reqs();
        neg();
        chk("hw_haddr", if0.HADDR, 32'h7002);
        chk("hw_hsize", if0.HSIZE, 3'b001);
        cyc(); cyc(); neg();
        chk("hw_rvalid", if0.data_rvalid_o, 1'b1);
        repeat (3) cyc();

        chk("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
